// File: rtl/level_sequencer.sv
// Walks a level note ROM one entry per beat, prefetching the next note so each
// spawn is issued on the beat edge itself. Stops at the end marker or the last address.
module level_sequencer #(
    parameter int                    ADDR_WIDTH = 6,
    parameter int                    DATA_WIDTH = 4,
    parameter logic [DATA_WIDTH-1:0] END_MARK   = '1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic                  pause_i,
    input  logic                  beat_tick_i,
    input  logic [DATA_WIDTH-1:0] note_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] spawn_o,
    output logic                  spawn_valid_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  overrun_o
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_LATCH     = 3'd2,
        S_WAIT_BEAT = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   note_q, note_d;
    logic [DATA_WIDTH-1:0]   spawn_q, spawn_d;
    logic                    spawn_valid_q, spawn_valid_d;
    logic                    beat_pend_q, beat_pend_d;
    logic                    overrun_q, overrun_d;

    logic start_ok;
    logic fire;
    logic at_last;
    logic early_beat;

    // start is only honoured when no level is in flight; it overrides pause
    assign start_ok   = ((state_q == S_IDLE) || (state_q == S_DONE)) && start_i;
    assign fire       = (state_q == S_WAIT_BEAT) && (beat_tick_i || beat_pend_q) && !pause_i;
    assign at_last    = (addr_q == LAST_ADDR);
    assign early_beat = ((state_q == S_FETCH) || (state_q == S_LATCH)) && beat_tick_i && !pause_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            note_q        <= '0;
            spawn_q       <= '0;
            spawn_valid_q <= 1'b0;
            beat_pend_q   <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            note_q        <= note_d;
            spawn_q       <= spawn_d;
            spawn_valid_q <= spawn_valid_d;
            beat_pend_q   <= beat_pend_d;
            overrun_q     <= overrun_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (!pause_i) state_d = S_LATCH;
            end
            S_LATCH: begin
                if (!pause_i) state_d = (note_i == END_MARK) ? S_DONE : S_WAIT_BEAT;
            end
            S_WAIT_BEAT: begin
                if (fire) state_d = at_last ? S_DONE : S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        addr_d        = addr_q;
        note_d        = note_q;
        spawn_d       = spawn_q;
        spawn_valid_d = 1'b0;
        beat_pend_d   = beat_pend_q;
        overrun_d     = overrun_q;

        if (start_ok) begin
            addr_d      = '0;
            beat_pend_d = 1'b0;
            overrun_d   = 1'b0;
        end

        if ((state_q == S_LATCH) && !pause_i) begin
            note_d = note_i;
        end

        // a second beat arriving before the first could be issued is lost
        if (early_beat) begin
            if (beat_pend_q) overrun_d   = 1'b1;
            else             beat_pend_d = 1'b1;
        end

        if (fire) begin
            spawn_d       = note_q;
            spawn_valid_d = (note_q != '0);
            beat_pend_d   = 1'b0;
            if (!at_last) addr_d = addr_q + ADDR_ONE;
        end
    end

    always_comb begin
        busy_o = (state_q == S_FETCH) || (state_q == S_LATCH) || (state_q == S_WAIT_BEAT);
        done_o = (state_q == S_DONE);
    end

    assign addr_o        = addr_q;
    assign spawn_o       = spawn_q;
    assign spawn_valid_o = spawn_valid_q;
    assign overrun_o     = overrun_q;

endmodule
